// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and the iteration count.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/muldiv_sign_adjust.sv
// -----------------------------------------------------------------------------
// muldiv_sign_adjust
// Combinational sign correction applied to the raw magnitude result when
// HI/LO are loaded.
//   raw_i      : {hi, lo} magnitude result ({remainder, quotient} for divides)
//   is_div_i   : 1 for a divide, 0 for a multiply
//   neg_res_i  : negate the product (64-bit) or the quotient
//   neg_rem_i  : negate the remainder (dividend was negative)
//   hi_o/lo_o  : corrected HI/LO values
// -----------------------------------------------------------------------------
module muldiv_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               is_div_i,
  input  logic               neg_res_i,
  input  logic               neg_rem_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_res_i ? (~raw_i + 1'b1) : raw_i;
    quo  = neg_res_i ? (~raw_i[WIDTH-1:0] + 1'b1) : raw_i[WIDTH-1:0];
    rem  = neg_rem_i ? (~raw_i[2*WIDTH-1:WIDTH] + 1'b1) : raw_i[2*WIDTH-1:WIDTH];
    if (is_div_i) begin
      hi_o = rem;
      lo_o = quo;
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; every op
// takes 32 RUN cycles. MTHI/MTLO writes are accepted only while idle.
// Build option: MULDIV_SIGNED_EN enables signed MULT/DIV; without it op[1]
// is ignored and all ops are unsigned.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, op, a, b     : operation request, opcode, rs / rt operands
//   wr_hi, wr_lo,
//   wr_data             : MTHI/MTLO write strobes and data
//   busy                : operation in progress (stall request)
//   done, div_by_zero   : one-cycle result pulse, divide-by-zero flag
//   hi, lo              : HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 bzero_q, bzero_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // {acc_hi, multiplier} or {rem, quo}
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dz_q, dz_d;

  // Operand magnitudes and result signs at start
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  always_comb begin
    a_neg = op[1] & a[WIDTH-1];
    b_neg = op[1] & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end
`else
  logic                 unused_op_msb;
  assign unused_op_msb = op[1];
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = a;
    b_mag = b;
  end
`endif

  // One iteration of either algorithm
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    // Restore on a negative trial; a zero divisor never restores, which
    // leaves the dividend in the remainder and all-ones in the quotient.
    if (!div_trial[WIDTH+1])
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    step = is_div_q ? div_next : mul_next;
  end

  // Final HI/LO values
  logic [WIDTH-1:0]     adj_hi, adj_lo;

`ifdef MULDIV_SIGNED_EN
  muldiv_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
    .raw_i     (step),
    .is_div_i  (is_div_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .hi_o      (adj_hi),
    .lo_o      (adj_lo)
  );
`else
  assign adj_hi = step[2*WIDTH-1:WIDTH];
  assign adj_lo = step[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    bzero_d  = bzero_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A write in the same cycle as start is dropped
          state_d  = ST_RUN;
          cnt_d    = '0;
          is_div_d = op[0];
          bzero_d  = (b == '0);
          opnd_d   = op[0] ? b_mag : a_mag;
          acc_d    = op[0] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
`ifdef MULDIV_SIGNED_EN
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
`endif
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      ST_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) begin
          state_d = ST_IDLE;
          hi_d    = adj_hi;
          // Divide by zero reports all-ones regardless of operand signs
          lo_d    = (is_div_q && bzero_q) ? '1 : adj_lo;
          done_d  = 1'b1;
          dz_d    = is_div_q & bzero_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    bzero_q  <= bzero_d;
    opnd_q   <= opnd_d;
    acc_q    <= acc_d;
`ifdef MULDIV_SIGNED_EN
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
`endif
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from plain SV arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        m;
    bit          sg;
    longint      sx, sy, p, q, r;
    logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
    sg = o[1];
`else
    sg = 1'b0;
`endif
    m = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o[0]) begin
      if (sg) begin
        p = sx * sy;
        up = 64'(p);
      end else begin
        up = {32'b0, x} * {32'b0, y};
      end
      m.hi = up[63:32];
      m.lo = up[31:0];
    end else if (y == 32'b0) begin
      m.hi = x;
      m.lo = 32'hFFFF_FFFF;
      m.dz = 1'b1;
    end else if (sg) begin
      q = sx / sy;
      r = sx % sy;
      m.lo = q[31:0];
      m.hi = r[31:0];
    end else begin
      m.lo = x / y;
      m.hi = x % y;
    end
    return m;
  endfunction

  // Drive one op, wait for done, pop the scoreboard and compare
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
    logic [31:0] hi0, lo0;
    exp_t        e;
    int          n;
    bit          seen;
    hi0 = hi;
    lo0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_start: got %b want 1", nm, busy);
    end
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      step();
      n++;
      if (n == 16) begin
        total++;
        if (hi !== hi0 || lo !== lo0) begin
          bad++;
          $display("FAIL %s hold_during_run: got hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, hi0, lo0);
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || n != 32) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d) want 32", nm, n, seen);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard_empty: got no entry want one", nm);
    end else begin
      e = sb.pop_front();
      if ({div_by_zero, hi, lo} !== e || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s result: got dz=%b hi=%h lo=%h busy=%b want dz=%b hi=%h lo=%h busy=0",
                 nm, div_by_zero, hi, lo, busy, e.dz, e.hi, e.lo);
      end
    end
    step();
    total++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse_width: got done=%b dz=%b want 0 0", nm, done, div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want 0 0 0 0 0",
               busy, done, div_by_zero, hi, lo);
    end
  endtask

  task automatic test_multu();
    sb.push_back('{1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
  endtask

  task automatic test_divu();
    sb.push_back('{1'b0, 32'd2, 32'd14});
    run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
  endtask

  task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
    sb.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, "mult_neg3_5");
    sb.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    sb.push_back('{1'b0, 32'h0, 32'h8000_0000});
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
`else
    sb.push_back('{1'b0, 32'h0000_0004, 32'hFFFF_FFF1});
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, "mult_as_multu");
    sb.push_back('{1'b0, 32'h0000_0001, 32'h7FFF_FFFC});
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_as_divu");
    sb.push_back('{1'b0, 32'h8000_0000, 32'h0});
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_big_unsigned");
`endif
  endtask

  task automatic test_div_by_zero();
    sb.push_back('{1'b1, 32'h0000_1234, 32'hFFFF_FFFF});
    run_op(2'b01, 32'h0000_1234, 32'h0, "divu_by_zero");
    sb.push_back('{1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF});
    run_op(2'b11, 32'hFFFF_FFF0, 32'h0, "div_by_zero_neg");
  endtask

  task automatic test_busy_ignore();
    int n;
    bit seen;
    sb.push_back('{1'b0, 32'd2, 32'd14});
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      step();
      n++;
      start = (n == 10);
      if (n == 10) begin op = 2'b00; a = 32'd3; b = 32'd3; end
      wr_hi = (n == 15);
      wr_data = 32'h0000_AAAA;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0; wr_hi = 1'b0;
    total++;
    if (!seen || n != 32) begin
      bad++;
      $display("FAIL busy_ignore latency: got %0d want 32", n);
    end
    total++;
    begin
      exp_t e;
      e = sb.pop_front();
      if ({div_by_zero, hi, lo} !== e) begin
        bad++;
        $display("FAIL busy_ignore result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen || hi !== 32'd2 || lo !== 32'd14) begin
      bad++;
      $display("FAIL busy_ignore no_second_op: got extra=%b hi=%h lo=%h want 0 2 14", seen, hi, lo);
    end
  endtask

  task automatic test_mtlo_mthi();
    logic [31:0] hi0;
    hi0 = hi;
    wr_lo = 1'b1; wr_data = 32'h55;
    step();
    wr_lo = 1'b0;
    total++;
    if (lo !== 32'h55 || hi !== hi0) begin
      bad++;
      $display("FAIL mtlo: got hi=%h lo=%h want hi=%h lo=00000055", hi, lo, hi0);
    end
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_0001;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    total++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want cafe0001 cafe0001", hi, lo);
    end
  endtask

  // Write strobe with start is dropped: hold check inside run_op sees it
  task automatic test_start_wins();
    wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 32'h0, 32'd12});
    run_op(2'b00, 32'd3, 32'd4, "start_wins");
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_op: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_op no_done: got activity after reset want none");
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 7) y = 32'h0;
      sb.push_back(model(o, x, y));
      run_op(o, x, y, "random");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    test_reset();
    test_multu();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_busy_ignore();
    test_mtlo_mthi();
    test_start_wins();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS-32 datapath. Executes MULT/MULTU/DIV/DIVU over 32 iteration cycles and serves MTHI/MTLO writes. Its hi/lo outputs feed the 32-bit 2:1 write-back selects (MFHI/MFLO path) directly downstream. The busy flag drives the pipeline stall logic.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled while idle.
- `op`  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `a`  in  32  multiplicand or dividend (rs).
- `b`  in  32  multiplier or divisor (rt).
- `wr_hi`  in  1  MTHI write strobe.
- `wr_lo`  in  1  MTLO write strobe.
- `wr_data`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO are loaded with a result.
- `div_by_zero`  out  1  one-cycle pulse, coincident with `done`, for a divide with `b == 0`.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- FSM has two states: IDLE and RUN.
- IDLE to RUN on `start` while `busy` is 0.
  - Latch the operands as magnitudes, the op, and the result signs.
  - Clear the 5-bit iteration counter.
- RUN performs one iteration per cycle, 32 in total.
  - Counter value 31 returns the FSM to IDLE.
  - On that same edge HI/LO are loaded and `done` is pulsed.
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring division.
  - Quotient goes to LO, remainder to HI.
- Signed ops:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Product is negated (64-bit) when the operand signs differ.
  - Sign correction is combinational at the final load and adds no cycles.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero gives HI=a, LO=0xFFFFFFFF, `div_by_zero`=1. No trap.
- `start` while busy is ignored.
  - Pipeline stall on `busy` guarantees this never happens legitimately.
- MTHI/MTLO while idle: the named register takes `wr_data` on the next edge.
  - `wr_hi` and `wr_lo` may be asserted together.
- MTHI/MTLO while busy is ignored.
- `start` and a write in the same idle cycle: `start` wins and the write is dropped.
- Reset, including mid-operation, aborts any operation and forces:
  - IDLE state;
  - `busy`=0, `done`=0, `div_by_zero`=0;
  - `hi`=0, `lo`=0.

## Timing
- `start` is sampled at edge E0.
- `busy` is 1 from after E0 until E32, and 0 after E32.
- HI/LO are updated at E32.
- `done` (and `div_by_zero` if applicable) is high for exactly the cycle after E32.
- The earliest next `start` is sampled at E33. Back-to-back throughput is one op per 33 cycles.
- Latency is identical for all four ops and for divide-by-zero.
- `hi`/`lo` hold their previous values throughout RUN. No intermediate values are visible.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV are signed as described above.
- `MULDIV_SIGNED_EN` undefined:
  - `op[1]` is ignored, so MULT behaves as MULTU and DIV as DIVU.
  - The sign-latch and negation logic is removed.
  - Latency is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op encodings (`OP_MULTU`, `OP_DIVU`, `OP_MULT`, `OP_DIV`);
  - the state encoding (`ST_IDLE`, `ST_RUN`);
  - `ITER_COUNT`=32.
- One sub-module, `muldiv_sign_adjust`:
  - Combinational.
  - Takes the raw 64-bit result, op, and sign flags.
  - Produces the final HI/LO.
  - Instantiated only under `MULDIV_SIGNED_EN`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- DIVU a=100, b=7 -> LO=14, HI=2. MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Without the macro, the same op as DIVU gives LO=0x7FFFFFFC, HI=1.
- DIVU a=0x1234, b=0 -> HI=0x1234, LO=0xFFFFFFFF, `div_by_zero` and `done` high in the same single cycle.
- Second `start` at cycle 10 of a running op, plus `wr_hi`=1 with 0xAAAA at cycle 15 -> both ignored, and the first result is unchanged.
- MTLO 0x55 while idle -> LO=0x55 next cycle. `rst` at cycle 20 of a DIV -> `busy`=0, HI=LO=0, no `done` pulse.
